// File: rtl/p1_ctrl_pkg.sv
// p1_ctrl_pkg
// Shared types and constants for the pool-1 -> conv2 read-side scheduler.
//   p1_state_e     : scheduler state (IDLE, FILL, STREAM)
//   P1_MAP_W       : pooled map edge length
//   P1_FRAME_WORDS : words per pooled map (P1_MAP_W * P1_MAP_W)
//   P1_FIFO_DEPTH  : depth of the external p1_fifo in words
package p1_ctrl_pkg;

  localparam int P1_MAP_W       = 13;
  localparam int P1_FRAME_WORDS = P1_MAP_W * P1_MAP_W;
  localparam int P1_FIFO_DEPTH  = 512;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } p1_state_e;

endpackage

// File: rtl/p1_occ_counter.sv
// p1_occ_counter
// Up/down occupancy counter for the external p1_fifo. Saturation at the
// FIFO depth is enforced by the caller through full_reject, which marks a
// write that arrived while the FIFO was full and no read freed a slot.
// Ports:
//   clk         : clock
//   rst_n       : synchronous, active-high reset
//   inc         : write strobe into the FIFO
//   dec         : read strobe out of the FIFO (never issued when empty)
//   full_reject : the write this cycle is dropped because the FIFO is full
//   occupancy   : words currently held in the FIFO
//   overflow    : sticky, set by any dropped write; cleared only by reset
module p1_occ_counter #(
  parameter int OCC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             full_reject,
  output logic [OCC_W-1:0] occupancy,
  output logic             overflow
);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      occupancy <= '0;
      overflow  <= 1'b0;
    end else if (full_reject) begin
      // A rejected write implies no read this cycle, so the count holds.
      overflow <= 1'b1;
    end else begin
      unique case ({inc, dec})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/p1_c2_stream_ctrl.sv
// p1_c2_stream_ctrl
// Read-side scheduler for the pool-1 -> conv2 buffer. Tracks p1_fifo
// occupancy from its write strobes and streams one full frame at a time to
// conv2 once START_LEVEL words are buffered, reading only while conv2 is
// ready. A frame, once started, always runs to completion.
// Ports:
//   clk            : clock
//   rst_n          : synchronous, active-high reset (shared with FIFO srst)
//   en             : level enable for frame streaming
//   wr_valid       : FIFO write strobe (pool-1 data_in_valid)
//   c2_ready       : conv2 can accept a word this cycle
//   fifo_rd_en     : FIFO read enable (combinational)
//   data_out_valid : FIFO dout holds a word for conv2 (read latency 1)
//   occupancy      : words currently held in the FIFO
//   busy           : high while streaming a frame
//   frame_done     : one-cycle pulse with the last word's data_out_valid
//   frame_cnt      : completed frames, wraps 255 -> 0
//   overflow       : sticky, a write arrived while the FIFO was full
//   underflow_req  : sticky, conv2 was ready mid-frame but the FIFO was empty
module p1_c2_stream_ctrl
  import p1_ctrl_pkg::*;
#(
  parameter int DEPTH       = P1_FIFO_DEPTH,
  parameter int FRAME_WORDS = P1_FRAME_WORDS,
  parameter int START_LEVEL = P1_FRAME_WORDS,
  parameter int OCC_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_valid,
  input  logic             c2_ready,
  output logic             fifo_rd_en,
  output logic             data_out_valid,
  output logic [OCC_W-1:0] occupancy,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output logic             overflow,
  output logic             underflow_req
);

  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] FRAME_C = OCC_W'(FRAME_WORDS);
  localparam logic [OCC_W-1:0] LAST_C  = OCC_W'(FRAME_WORDS - 1);
  localparam logic [OCC_W-1:0] START_C = OCC_W'(START_LEVEL);

  p1_state_e        state;
  p1_state_e        state_nxt;
  logic [OCC_W-1:0] rd_cnt;
  logic             want_rd;
  logic             last_rd;
  logic             wr_reject;

  // want_rd is the read request before the empty check; when it is high
  // with an empty FIFO, conv2 is being starved mid-frame.
  assign want_rd    = (state == STREAM) && c2_ready && (rd_cnt < FRAME_C);
  assign fifo_rd_en = want_rd && (occupancy != '0);
  assign last_rd    = fifo_rd_en && (rd_cnt == LAST_C);
  assign wr_reject  = wr_valid && (occupancy == DEPTH_C) && !fifo_rd_en;
  assign busy       = (state == STREAM);

  p1_occ_counter #(
    .OCC_W(OCC_W)
  ) u_occ (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (wr_valid),
    .dec        (fifo_rd_en),
    .full_reject(wr_reject),
    .occupancy  (occupancy),
    .overflow   (overflow)
  );

  // NOTE: state_nxt is given a default before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = FILL;
      FILL: begin
        if (!en)                       state_nxt = IDLE;
        else if (occupancy >= START_C) state_nxt = STREAM;
      end
      // Leaving STREAM only on the final read keeps frames whole even when
      // en drops mid-frame.
      STREAM:  if (last_rd) state_nxt = en ? FILL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state          <= IDLE;
      rd_cnt         <= '0;
      data_out_valid <= 1'b0;
      frame_done     <= 1'b0;
      frame_cnt      <= '0;
      underflow_req  <= 1'b0;
    end else begin
      state          <= state_nxt;
      data_out_valid <= fifo_rd_en;
      frame_done     <= last_rd;
      if (last_rd) begin
        rd_cnt    <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + OCC_W'(1);
      end
      if (want_rd && (occupancy == '0)) underflow_req <= 1'b1;
    end
  end

endmodule

// File: tb/tb_p1_c2_stream_ctrl.sv
// tb_p1_c2_stream_ctrl
// Drives two scheduler instances (START_LEVEL 169 and 100) with a shared
// stimulus and compares every output each cycle against a frame-level
// reference model, plus a few directed end-of-scenario expectations.
module tb_p1_c2_stream_ctrl;

  localparam int DEPTH = 512;
  localparam int FW    = 169;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n    = 1'b1;
  logic en       = 1'b0;
  logic wr_valid = 1'b0;
  logic c2_ready = 1'b0;

  logic       rd_o   [2];
  logic       dv_o   [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       ovf_o  [2];
  logic       unf_o  [2];
  logic [9:0] occ_o  [2];
  logic [7:0] fcnt_o [2];

  p1_c2_stream_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .c2_ready(c2_ready),
    .fifo_rd_en(rd_o[0]), .data_out_valid(dv_o[0]), .occupancy(occ_o[0]),
    .busy(busy_o[0]), .frame_done(done_o[0]), .frame_cnt(fcnt_o[0]),
    .overflow(ovf_o[0]), .underflow_req(unf_o[0])
  );

  p1_c2_stream_ctrl #(.START_LEVEL(100)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .c2_ready(c2_ready),
    .fifo_rd_en(rd_o[1]), .data_out_valid(dv_o[1]), .occupancy(occ_o[1]),
    .busy(busy_o[1]), .frame_done(done_o[1]), .frame_cnt(fcnt_o[1]),
    .overflow(ovf_o[1]), .underflow_req(unf_o[1])
  );

  int errors = 0;
  int checks = 0;

  // Reference model. mode: 0 = disabled, 1 = waiting for a frame's worth of
  // data, 2 = streaming a frame. nread counts words read in the frame.
  int m_sl    [2];
  int m_mode  [2];
  int m_occ   [2];
  int m_nread [2];
  int m_fcnt  [2];
  bit m_ovf   [2];
  bit m_unf   [2];
  bit m_dv    [2];
  bit m_done  [2];
  bit m_live = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit model_read(input int k);
    return (m_mode[k] == 2) && c2_ready && (m_occ[k] > 0) && (m_nread[k] < FW);
  endfunction

  task automatic compare(input int k);
    check($sformatf("rd_en%0d", k), 32'(rd_o[k]),   32'(model_read(k)));
    check($sformatf("dv%0d", k),    32'(dv_o[k]),   32'(m_dv[k]));
    check($sformatf("occ%0d", k),   32'(occ_o[k]),  32'(m_occ[k]));
    check($sformatf("busy%0d", k),  32'(busy_o[k]), 32'(m_mode[k] == 2));
    check($sformatf("done%0d", k),  32'(done_o[k]), 32'(m_done[k]));
    check($sformatf("fcnt%0d", k),  32'(fcnt_o[k]), 32'(m_fcnt[k]));
    check($sformatf("ovf%0d", k),   32'(ovf_o[k]),  32'(m_ovf[k]));
    check($sformatf("unf%0d", k),   32'(unf_o[k]),  32'(m_unf[k]));
  endtask

  task automatic model_step(input int k);
    bit rd;
    bit last;
    bit wr_ok;
    int occ0;
    if (rst_n) begin
      m_mode[k] = 0; m_occ[k] = 0; m_nread[k] = 0; m_fcnt[k] = 0;
      m_ovf[k] = 0;  m_unf[k] = 0; m_dv[k] = 0;    m_done[k] = 0;
      return;
    end
    rd    = model_read(k);
    occ0  = m_occ[k];
    last  = rd && (m_nread[k] == FW - 1);
    wr_ok = wr_valid && !((occ0 == DEPTH) && !rd);
    if (wr_valid && !wr_ok) m_ovf[k] = 1'b1;
    if ((m_mode[k] == 2) && c2_ready && (occ0 == 0) && (m_nread[k] < FW)) m_unf[k] = 1'b1;
    m_occ[k]   = occ0 + int'(wr_ok) - int'(rd);
    m_dv[k]    = rd;
    m_done[k]  = last;
    m_nread[k] = m_nread[k] + int'(rd);
    if (last) m_fcnt[k] = (m_fcnt[k] + 1) % 256;
    case (m_mode[k])
      0: if (en) m_mode[k] = 1;
      1: begin
        if (!en) m_mode[k] = 0;
        else if (occ0 >= m_sl[k]) m_mode[k] = 2;
      end
      default: if (last) begin
        m_mode[k]  = en ? 1 : 0;
        m_nread[k] = 0;
      end
    endcase
  endtask

  // One clock cycle: drive inputs at the falling edge, compare just after,
  // then advance the model across the rising edge.
  task automatic tick(input bit r, input bit e, input bit w, input bit c);
    @(negedge clk);
    rst_n = r; en = e; wr_valid = w; c2_ready = c;
    #1;
    if (m_live) for (int k = 0; k < 2; k++) compare(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    if (r) m_live = 1'b1;
    #1;
  endtask

  initial begin
    m_sl[0] = 169;
    m_sl[1] = 100;
    repeat (2) tick(1, 0, 0, 0);

    // One frame written back-to-back with conv2 always ready.
    repeat (169) tick(0, 1, 1, 1);
    repeat (200) tick(0, 1, 0, 1);
    check("s1_fcnt", 32'(fcnt_o[0]), 32'd1);
    check("s1_occ",  32'(occ_o[0]),  32'd0);

    // conv2 ready alternating during the stream.
    tick(1, 0, 0, 0);
    repeat (169) tick(0, 1, 1, 0);
    for (int i = 0; i < 400; i++) tick(0, 1, 0, bit'(i % 2 == 0));
    check("s2_fcnt", 32'(fcnt_o[0]), 32'd1);

    // Two frames preloaded: back-to-back streaming.
    tick(1, 0, 0, 0);
    repeat (338) tick(0, 1, 1, 0);
    repeat (400) tick(0, 1, 0, 1);
    check("s3_fcnt", 32'(fcnt_o[0]), 32'd2);
    check("s3_occ",  32'(occ_o[0]),  32'd0);

    // Starvation on the START_LEVEL=100 instance, then recovery.
    tick(1, 0, 0, 0);
    repeat (120) tick(0, 1, 1, 1);
    repeat (150) tick(0, 1, 0, 1);
    check("s4_unf",  32'(unf_o[1]),  32'd1);
    check("s4_busy", 32'(busy_o[1]), 32'd1);
    repeat (60)  tick(0, 1, 1, 1);
    repeat (200) tick(0, 1, 0, 1);
    check("s4_fcnt", 32'(fcnt_o[1]), 32'd1);

    // Overflow with reads disabled, then write+read at full.
    tick(1, 0, 0, 0);
    repeat (513) tick(0, 0, 1, 0);
    check("s5_occ", 32'(occ_o[0]), 32'd512);
    check("s5_ovf", 32'(ovf_o[0]), 32'd1);
    repeat (20) tick(0, 1, 1, 1);
    check("s5_occ_rw", 32'(occ_o[0]), 32'd512);

    // Reset mid-frame.
    tick(1, 0, 0, 0);
    repeat (169) tick(0, 1, 1, 0);
    repeat (80)  tick(0, 1, 0, 1);
    tick(1, 1, 0, 1);
    check("s6_rd",   32'(rd_o[0]),   32'd0);
    check("s6_dv",   32'(dv_o[0]),   32'd0);
    check("s6_done", 32'(done_o[0]), 32'd0);
    check("s6_busy", 32'(busy_o[0]), 32'd0);
    check("s6_occ",  32'(occ_o[0]),  32'd0);
    check("s6_fcnt", 32'(fcnt_o[0]), 32'd0);
    repeat (169) tick(0, 1, 1, 1);
    repeat (200) tick(0, 1, 0, 1);
    check("s6_fcnt_after", 32'(fcnt_o[0]), 32'd1);

    // Randomized traffic with occasional enable drops and resets.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      tick(bit'($urandom_range(399) == 0), bit'($urandom_range(15) != 0),
           bit'($urandom_range(1)), bit'($urandom_range(9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
